// File: rtl/multichannel_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcram_pkg
// Brief    : Shared constants, tag type and width helper for multichannel_ram.
// Revision : 1.0
// ============================================================================
package mcram_pkg;

  localparam int RD_LATENCY = 2;
  localparam int MAX_CH     = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int TAG_WIDTH = clog2(MAX_CH);

  typedef logic [TAG_WIDTH-1:0] ch_tag_t;

endpackage
`default_nettype wire

// File: rtl/multichannel_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : multichannel_ram_if
// Brief    : Write port and per-channel read handshake bundle.
// Revision : 1.0
// ============================================================================
interface multichannel_ram_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
);
  logic                         wr_en;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic [DATA_WIDTH/8-1:0]      wr_be;
  logic [NUM_CH-1:0]            rd_req;
  logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_CH-1:0]            rd_gnt;
  logic [NUM_CH-1:0]            rd_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_req, rd_addr,
    input  rd_gnt, rd_valid, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_req, rd_addr,
    output rd_gnt, rd_valid, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/multichannel_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter with combinational one-hot grant and index.
// Revision : 1.0
// ============================================================================
module rr_arbiter
  import mcram_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_req,
  output logic [NUM_CH-1:0] o_gnt,
  output ch_tag_t           o_idx,
  output logic              o_valid
);
  localparam logic [NUM_CH-1:0] c_one = NUM_CH'(1);

  ch_tag_t              r_ptr;
  ch_tag_t              w_idx;
  ch_tag_t              w_next_ptr;
  logic                 w_found;
  logic [NUM_CH-1:0]    w_rot;
  logic [TAG_WIDTH:0]   w_sum;

  // Rotating the request vector by ptr turns the wrap-around scan into a plain priority scan.
  always_comb begin
    w_rot   = NUM_CH'({i_req, i_req} >> r_ptr);
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (TAG_WIDTH+1)'(k);
        if (w_sum >= (TAG_WIDTH+1)'(NUM_CH)) w_sum = w_sum - (TAG_WIDTH+1)'(NUM_CH);
        w_idx   = w_sum[TAG_WIDTH-1:0];
      end
    end
    w_next_ptr = (w_idx == ch_tag_t'(NUM_CH-1)) ? '0 : w_idx + ch_tag_t'(1);
  end

  assign o_valid = w_found & ~rst;
  assign o_gnt   = o_valid ? (c_one << w_idx) : '0;
  assign o_idx   = w_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ptr <= '0;
    else if (w_found) r_ptr <= w_next_ptr;
  end

endmodule
`default_nettype wire

// File: rtl/multichannel_ram.sv
`default_nettype none
// ============================================================================
// Module   : multichannel_ram
// Brief    : Byte-enabled sample RAM shared by NUM_CH round-robin read channels.
//            Define MULTICHANNEL_RAM_BYPASS_EN for per-byte write-first reads.
// Revision : 1.0
// ============================================================================
module multichannel_ram
  import mcram_pkg::*;
#(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
) (
  input logic              clk,
  input logic              rst,
  multichannel_ram_if.slave bus
);
  localparam int                c_nbytes = DATA_WIDTH / 8;
  localparam logic [NUM_CH-1:0] c_one    = NUM_CH'(1);

  logic [DATA_WIDTH-1:0]        r_mem [0:(1<<ADDR_WIDTH)-1];
  logic                         r_s1_valid;
  ch_tag_t                      r_s1_tag;
  logic [DATA_WIDTH-1:0]        r_s1_data;
  logic [NUM_CH-1:0]            r_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] r_data;

  logic [NUM_CH-1:0]            w_gnt;
  ch_tag_t                      w_idx;
  logic                         w_gnt_valid;
  logic [ADDR_WIDTH-1:0]        w_rd_addr;
  logic [DATA_WIDTH-1:0]        w_rd_word;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (bus.rd_req),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_gnt_valid)
  );

  assign w_rd_addr = bus.rd_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];

  always_comb begin
    w_rd_word = r_mem[w_rd_addr];
`ifdef MULTICHANNEL_RAM_BYPASS_EN
    if (bus.wr_en && (bus.wr_addr == w_rd_addr)) begin
      for (int b = 0; b < c_nbytes; b++) begin
        if (bus.wr_be[b]) w_rd_word[8*b +: 8] = bus.wr_data[8*b +: 8];
      end
    end
`endif
  end

  // Array has no reset: contents survive rst and are undefined at power-up.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      for (int b = 0; b < c_nbytes; b++) begin
        if (bus.wr_be[b]) r_mem[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_data  <= '0;
      r_valid    <= '0;
      r_data     <= '0;
    end else begin
      r_s1_valid <= w_gnt_valid;
      r_s1_tag   <= w_idx;
      r_s1_data  <= w_rd_word;
      r_valid    <= r_s1_valid ? (c_one << r_s1_tag) : '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_s1_valid && (r_s1_tag == ch_tag_t'(i)))
          r_data[i*DATA_WIDTH +: DATA_WIDTH] <= r_s1_data;
      end
    end
  end

  assign bus.rd_gnt   = w_gnt;
  assign bus.rd_valid = r_valid;
  assign bus.rd_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_multichannel_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_multichannel_ram
// Brief    : Directed self-checking bench for multichannel_ram.
// Revision : 1.0
// ============================================================================
module tb_multichannel_ram;
  import mcram_pkg::*;

  localparam int AW = 19;
  localparam int DW = 16;
  localparam int NC = 4;

`ifdef MULTICHANNEL_RAM_BYPASS_EN
  localparam logic [15:0] c_coll = 16'h00FF;
`else
  localparam logic [15:0] c_coll = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  multichannel_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC)) bus_if ();

  multichannel_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW/8-1:0] be);
    bus_if.wr_en   = en;
    bus_if.wr_addr = a;
    bus_if.wr_data = d;
    bus_if.wr_be   = be;
  endtask

  task automatic set_rd(input int ch, input logic req, input logic [AW-1:0] a);
    bus_if.rd_req[ch]           = req;
    bus_if.rd_addr[ch*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] data_of(input int ch);
    return bus_if.rd_data[ch*DW +: DW];
  endfunction

  initial begin
    set_wr(1'b0, '0, '0, '0);
    bus_if.rd_req  = '0;
    bus_if.rd_addr = '0;

    // Reset with every channel requesting: no grant may leak out.
    rst = 1'b1;
    bus_if.rd_req = '1;
    step(); settle();
    check("rst_gnt",   bus_if.rd_gnt,   64'h0);
    check("rst_valid", bus_if.rd_valid, 64'h0);
    check("rst_data",  bus_if.rd_data,  64'h0);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      settle();
      check($sformatf("rr_gnt%0d", k), bus_if.rd_gnt, 64'(1 << (k % NC)));
      check($sformatf("rr_valid%0d", k), bus_if.rd_valid,
            (k >= RD_LATENCY) ? 64'(1 << ((k - RD_LATENCY) % NC)) : 64'h0);
      step();
    end
    bus_if.rd_req = '0;
    settle(); check("rr_tail0", bus_if.rd_valid, 64'h4);
    step(); settle(); check("rr_tail1", bus_if.rd_valid, 64'h8);
    step();

    // Single read on ch1 right after the write edge.
    set_wr(1'b1, 19'h100, 16'hBEEF, 2'b11);
    step();
    set_wr(1'b0, '0, '0, '0);
    set_rd(1, 1'b1, 19'h100);
    settle(); check("single_gnt", bus_if.rd_gnt, 64'h2);
    step();
    set_rd(1, 1'b0, '0);
    settle(); check("single_t1_valid", bus_if.rd_valid, 64'h0);
    step(); settle();
    check("single_t2_valid", bus_if.rd_valid, 64'h2);
    check("single_t2_data",  data_of(1),      64'hBEEF);
    step(); settle();
    check("single_t3_valid", bus_if.rd_valid, 64'h0);
    check("single_hold",     data_of(1),      64'hBEEF);

    // Byte enables, including an all-zero enable write that must be ignored.
    set_wr(1'b1, 19'h5, 16'h1234, 2'b11); step();
    set_wr(1'b1, 19'h5, 16'hABCD, 2'b10); step();
    set_wr(1'b1, 19'h5, 16'h5555, 2'b00); step();
    set_wr(1'b0, '0, '0, '0);
    set_rd(2, 1'b1, 19'h5);
    settle(); check("be_gnt", bus_if.rd_gnt, 64'h4);
    step();
    set_rd(2, 1'b0, '0);
    step(); settle();
    check("be_valid", bus_if.rd_valid, 64'h4);
    check("be_data",  data_of(2),      64'hAB34);

    // Same-cycle read/write collision on address 7.
    set_wr(1'b1, 19'h7, 16'h0000, 2'b11); step();
    set_wr(1'b1, 19'h7, 16'hFFFF, 2'b01);
    set_rd(0, 1'b1, 19'h7);
    settle(); check("coll_gnt", bus_if.rd_gnt, 64'h1);
    step();
    set_wr(1'b0, '0, '0, '0);
    set_rd(0, 1'b0, '0);
    step(); settle();
    check("coll_data", data_of(0), 64'(c_coll));
    set_rd(0, 1'b1, 19'h7);
    settle(); check("coll_regnt", bus_if.rd_gnt, 64'h1);
    step();
    set_rd(0, 1'b0, '0);
    step(); settle();
    check("coll_after", data_of(0), 64'h00FF);

    // Bring ptr to 0, then saturate ch0..ch2 while ch3 waits.
    set_rd(3, 1'b1, 19'h100);
    settle(); check("hold_prep_gnt", bus_if.rd_gnt, 64'h8);
    step();
    for (int c = 0; c < 3; c++) set_rd(c, 1'b1, 19'h7);
    for (int k = 0; k < 4; k++) begin
      set_rd(3, 1'b1, (k == 3) ? 19'h5 : 19'h100);
      settle();
      check($sformatf("hold_gnt%0d", k), bus_if.rd_gnt, 64'(1 << k));
      step();
    end
    bus_if.rd_req = '0;
    settle();
    check("hold_valid_ch2", bus_if.rd_valid, 64'h4);
    check("hold_data_ch2",  data_of(2),      64'h00FF);
    step(); settle();
    check("hold_valid_ch3", bus_if.rd_valid, 64'h8);
    check("hold_data_ch3",  data_of(3),      64'hAB34);

    // Reset while ch0 and ch2 reads are in flight.
    set_rd(0, 1'b1, 19'h7);
    set_rd(2, 1'b1, 19'h7);
    settle(); check("mid_gnt0", bus_if.rd_gnt, 64'h1);
    step();
    settle(); check("mid_gnt2", bus_if.rd_gnt, 64'h4);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_gnt",   bus_if.rd_gnt,   64'h0);
    check("mid_rst_valid", bus_if.rd_valid, 64'h0);
    check("mid_rst_data",  bus_if.rd_data,  64'h0);
    step(); settle(); check("mid_rst_valid_a", bus_if.rd_valid, 64'h0);
    step(); settle(); check("mid_rst_valid_b", bus_if.rd_valid, 64'h0);
    rst = 1'b0;
    settle();
    check("post_rst_gnt",   bus_if.rd_gnt,   64'h1);
    check("post_rst_valid", bus_if.rd_valid, 64'h0);
    check("post_rst_data",  bus_if.rd_data,  64'h0);
    step();
    bus_if.rd_req = '0;
    settle(); check("post_rst_valid1", bus_if.rd_valid, 64'h0);
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multichannel_ram.md
# multichannel_ram

Single-clock sample RAM with one byte-enabled write port and NUM_CH independent read channels. The channels share one physical read port through a round-robin arbiter, and each channel has a req/gnt/valid handshake. It replaces the plain two-port sample store in the APU voice path, so several voice engines can fetch from one memory without external muxing.

## Interface
Parameters:
- ADDR_WIDTH, 19, word address width; depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 16, word width; must be a multiple of 8.
- NUM_CH, 4, number of read channels; 1 to 16.

Ports (clock is `clk`; reset is `rst`, asynchronous, active-high):
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit k covers wr_data[8k+7:8k].
- rd_req  in  NUM_CH  per-channel read request, level.
- rd_addr  in  NUM_CH*ADDR_WIDTH  per-channel address; channel i occupies slice i.
- rd_gnt  out  NUM_CH  one-hot grant, combinational, at most one bit set.
- rd_valid  out  NUM_CH  per-channel data-valid pulse, registered.
- rd_data  out  NUM_CH*DATA_WIDTH  per-channel held read data, registered.

## Operation
- Write: on a posedge with wr_en=1, each byte of mem[wr_addr] whose wr_be bit is 1 takes wr_data. Bytes with wr_be bit 0 keep their value. wr_en=1 with wr_be=0 changes nothing.
- Arbitration: round-robin pointer `ptr`. In each cycle, grant the first channel i with rd_req[i]=1, scanning from ptr upward and wrapping at NUM_CH. On a grant to channel i, ptr becomes (i+1) mod NUM_CH at the next edge. With no request, ptr holds.
- Handshake: the requester holds rd_req and its rd_addr slice stable until it sees rd_gnt. The request is consumed in the grant cycle. Keeping rd_req high after the grant issues another request.
- Pipeline:
  - stage 1 registers the granted address's array word and the channel tag.
  - stage 2 writes rd_data[tag] and pulses rd_valid[tag] for one cycle.
- Held data: each rd_data slice holds its last value until that channel's next rd_valid.
- Read/write collision (same cycle, same address): read-first, so the read returns the pre-write word, unless the bypass is enabled (see Configuration).
- Reset mid-operation:
  - in-flight reads are discarded and produce no rd_valid.
  - memory contents are not reset and are undefined at power-up.
- Reset values: ptr=0, stage valids 0, rd_valid=0, rd_data=0. rd_gnt=0 while rst is high.

## Timing
- Grant in cycle T (rd_req[i] and rd_gnt[i] both high).
- rd_valid[i]=1 and new rd_data[i] appear in cycle T+2. Fixed latency is 2, independent of contention.
- Aggregate throughput is one read per cycle; a single channel can receive one grant per cycle when it is alone.
- Worst-case wait under full contention is NUM_CH-1 cycles.
- A write at edge E is visible to any read granted in cycle E or later (the grant cycle follows edge E).

## Configuration
- Macro MULTICHANNEL_RAM_BYPASS_EN.
- Defined: when a read is granted in the same cycle as a write to the same address, each byte with wr_be=1 comes from wr_data. The other bytes come from the array. This gives write-first behaviour per byte.
- Undefined: pure read-first. No address comparator is built.

## Structure
- Package mcram_pkg holds:
  - constant RD_LATENCY=2.
  - function clog2 for channel-tag width.
  - typedef for the channel tag.
- Sub-module rr_arbiter (NUM_CH parameter) contains ptr, the combinational one-hot grant, and the granted index. The RAM array, the two stages and the bypass stay in the top module.

## Test plan
- Reset: assert rst mid-stream with channels 0 and 2 in flight -> no rd_valid afterwards, all rd_data=0, and the first grant after release goes to channel 0.
- Single read:
  - Stimulus: write 0xBEEF to address 0x100, then request on ch1 with address 0x100 (grant in cycle T).
  - Response: rd_valid[1]=1 only in T+2, with rd_data[1]=0xBEEF held afterwards.
- Round robin: all 4 channels request continuously from reset -> grant order 0,1,2,3,0,… and rd_valid order identical, each delayed 2 cycles.
- Byte enables:
  - Stimulus: mem[5]=0x1234, then write 0xABCD with wr_be=2'b10, then read address 5.
  - Response: 0xAB34.
- Collision: mem[7]=0x0000, then write 0xFFFF with wr_be=2'b01 in the same cycle as a ch0 grant for address 7.
  - Without the macro: read 0x0000.
  - With the macro: read 0x00FF.
  - A subsequent read returns 0x00FF in both builds.
- Request hold: ch3 asserts rd_req while ch0–ch2 are saturated and ptr=0 -> ch3 is granted within 3 cycles and its address slice is sampled only in the grant cycle.
